// File: rtl/fp_mac_pkg.sv
// -----------------------------------------------------------------------------
// fp_mac_pkg
// Shared definitions for the reduced-precision floating-point MAC datapath.
// Packed word layout: sign[18], exponent[17:10] (bias 127), fraction[9:0].
// Contents: field widths, bias/infinity codes, packed-field offsets, a
// result-class enum used by the round/pack stage, and a packing helper.
// -----------------------------------------------------------------------------
package fp_mac_pkg;

  localparam int MW       = 11;          // mantissa incl. hidden bit
  localparam int EW       = 8;           // exponent width
  localparam int FW       = 10;          // stored fraction width
  localparam int PW       = 2 * MW;      // full product width
  localparam int RW       = 1 + EW + FW; // packed result width
  localparam int SIGN_BIT = 18;
  localparam int EXP_LSB  = 10;

  localparam logic [EW-1:0] BIAS    = 8'd127;
  localparam logic [EW-1:0] EXP_INF = 8'hFF;

  // Outcome of the final rounding/saturation decision
  typedef enum logic [1:0] {
    RC_NORMAL = 2'd0,
    RC_ZERO   = 2'd1,
    RC_OVF    = 2'd2,
    RC_UNF    = 2'd3
  } rc_e;

  // Assemble a packed word from its three fields
  function automatic logic [RW-1:0] pack_fp(input logic          s,
                                            input logic [EW-1:0] e,
                                            input logic [FW-1:0] f);
    logic [RW-1:0] w;
    w                = {RW{1'b0}};
    w[SIGN_BIT]      = s;
    w[EXP_LSB +: EW] = e;
    w[FW-1:0]        = f;
    return w;
  endfunction

endpackage

// File: rtl/fm_step3_if.sv
// -----------------------------------------------------------------------------
// fm_step3_if
// Bundle between the multiplier row stage, fm_step3 and the accumulate stage.
//   in_valid / in_ex / in_sign / temp_p_r9 / temp_s_r9 : operands from upstream
//   out_valid / out_result / out_ovf / out_unf           : packed product out
// Modports: master = producer of in_* / consumer of out_*, slave = fm_step3.
// -----------------------------------------------------------------------------
interface fm_step3_if;
  import fp_mac_pkg::*;

  logic              in_valid;
  logic [EW-1:0]     in_ex;
  logic              in_sign;
  logic [PW-1:0]     temp_p_r9;
  logic [PW-1:0]     temp_s_r9;
  logic              out_valid;
  logic [RW-1:0]     out_result;
  logic              out_ovf;
  logic              out_unf;

  modport master (
    output in_valid, in_ex, in_sign, temp_p_r9, temp_s_r9,
    input  out_valid, out_result, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_ex, in_sign, temp_p_r9, temp_s_r9,
    output out_valid, out_result, out_ovf, out_unf
  );

endinterface

// File: rtl/fm_round_pack.sv
// -----------------------------------------------------------------------------
// fm_round_pack
// Combinational round-to-nearest-even, exponent saturation and packing.
//   i_sign    : result sign
//   i_zero    : product is exactly zero
//   i_frac    : normalised fraction (hidden bit removed)
//   i_guard   : first bit below the fraction
//   i_sticky  : OR of all remaining lower bits
//   i_exp9    : 9-bit biased exponent before rounding
//   o_result  : packed word
//   o_ovf     : saturated to infinity
//   o_unf     : flushed to zero from a nonzero value
// -----------------------------------------------------------------------------
module fm_round_pack
  import fp_mac_pkg::*;
(
  input  logic          i_sign,
  input  logic          i_zero,
  input  logic [FW-1:0] i_frac,
  input  logic          i_guard,
  input  logic          i_sticky,
  input  logic [EW:0]   i_exp9,
  output logic [RW-1:0] o_result,
  output logic          o_ovf,
  output logic          o_unf
);

  logic          w_round_up;
  logic [FW:0]   w_frac_inc;
  logic [EW+1:0] w_exp_rnd;   // one spare bit so exp9+1 can never wrap
  rc_e           w_class;

  // Rounding increment and mantissa-carry propagation into the exponent
  always_comb begin
    w_round_up = i_guard & (i_sticky | i_frac[0]);
    w_frac_inc = {1'b0, i_frac} + {{FW{1'b0}}, w_round_up};
    w_exp_rnd  = {1'b0, i_exp9} + {{(EW+1){1'b0}}, w_frac_inc[FW]};
  end

  // Classify with priority zero > overflow > underflow > normal
  always_comb begin
    w_class = RC_NORMAL;
    if (i_zero) begin
      w_class = RC_ZERO;
    end else if (w_exp_rnd >= {2'b00, EXP_INF}) begin
      w_class = RC_OVF;
    end else if (w_exp_rnd == {(EW+2){1'b0}}) begin
      w_class = RC_UNF;
    end else begin
      w_class = RC_NORMAL;
    end
  end

  // Pack the word and raise the exception flags for the chosen class
  always_comb begin
    o_result = {RW{1'b0}};
    o_ovf    = 1'b0;
    o_unf    = 1'b0;
    case (w_class)
      RC_ZERO: begin
        o_result = pack_fp(i_sign, {EW{1'b0}}, {FW{1'b0}});
      end
      RC_OVF: begin
        o_result = pack_fp(i_sign, EXP_INF, {FW{1'b0}});
        o_ovf    = 1'b1;
      end
      RC_UNF: begin
        o_result = pack_fp(i_sign, {EW{1'b0}}, {FW{1'b0}});
        o_unf    = 1'b1;
      end
      RC_NORMAL: begin
        // a carry out of the fraction leaves the low FW bits at zero
        o_result = pack_fp(i_sign, w_exp_rnd[EW-1:0], w_frac_inc[FW-1:0]);
      end
      default: begin
        o_result = {RW{1'b0}};
        o_ovf    = 1'b0;
        o_unf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fm_step3.sv
// -----------------------------------------------------------------------------
// fm_step3
// Final stage of the pipelined FP multiplier: adds the last partial-product
// row, normalises, rounds to nearest-even, saturates and packs. Free-running
// 3-stage pipeline (latency 3, one result per cycle, bubbles preserved).
//   CLK    : clock, rising edge
//   RESETn : asynchronous active-low reset, clears every stage
//   bus    : fm_step3_if.slave (in_* operands, out_* packed product)
// -----------------------------------------------------------------------------
module fm_step3
  import fp_mac_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETn,
  fm_step3_if.slave  bus
);

  // S1: summed product
  logic          r_s1_valid;
  logic [PW-1:0] r_s1_prod;
  logic [EW-1:0] r_s1_ex;
  logic          r_s1_sign;

  // S2: normalised fields
  logic          r_s2_valid;
  logic          r_s2_sign;
  logic          r_s2_zero;
  logic [FW-1:0] r_s2_frac;
  logic          r_s2_guard;
  logic          r_s2_sticky;
  logic [EW:0]   r_s2_exp9;

  // S3: outputs
  logic          r_out_valid;
  logic [RW-1:0] r_out_result;
  logic          r_out_ovf;
  logic          r_out_unf;

  logic [PW-1:0] w_prod;
  logic [FW-1:0] w_frac;
  logic          w_guard;
  logic          w_sticky;
  logic [EW:0]   w_exp9;
  logic          w_zero;
  logic [RW-1:0] w_rp_result;
  logic          w_rp_ovf;
  logic          w_rp_unf;

  // carry out of the 22-bit add is intentionally dropped
  assign w_prod = bus.temp_s_r9 + bus.temp_p_r9;

  // S1 register: row sum, exponent, sign and valid
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= {PW{1'b0}};
      r_s1_ex    <= {EW{1'b0}};
      r_s1_sign  <= 1'b0;
    end else begin
      r_s1_valid <= bus.in_valid;
      r_s1_prod  <= w_prod;
      r_s1_ex    <= bus.in_ex;
      r_s1_sign  <= bus.in_sign;
    end
  end

  // Normalise: a set top bit means the product is in [2,4) and shifts by one
  always_comb begin
    w_frac   = {FW{1'b0}};
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_exp9   = {1'b0, r_s1_ex};
    w_zero   = (r_s1_prod == {PW{1'b0}});
    if (r_s1_prod[PW-1]) begin
      w_frac   = r_s1_prod[PW-2 -: FW];
      w_guard  = r_s1_prod[PW-2-FW];
      w_sticky = |r_s1_prod[PW-3-FW:0];
      w_exp9   = {1'b0, r_s1_ex} + 9'd1;
    end else begin
      w_frac   = r_s1_prod[PW-3 -: FW];
      w_guard  = r_s1_prod[PW-3-FW];
      w_sticky = |r_s1_prod[PW-4-FW:0];
      w_exp9   = {1'b0, r_s1_ex};
    end
  end

  // S2 register: normalised fraction, rounding bits, exponent, zero flag
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_frac   <= {FW{1'b0}};
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_s2_exp9   <= {(EW+1){1'b0}};
    end else begin
      r_s2_valid  <= r_s1_valid;
      r_s2_sign   <= r_s1_sign;
      r_s2_zero   <= w_zero;
      r_s2_frac   <= w_frac;
      r_s2_guard  <= w_guard;
      r_s2_sticky <= w_sticky;
      r_s2_exp9   <= w_exp9;
    end
  end

  fm_round_pack u_round_pack (
    .i_sign   (r_s2_sign),
    .i_zero   (r_s2_zero),
    .i_frac   (r_s2_frac),
    .i_guard  (r_s2_guard),
    .i_sticky (r_s2_sticky),
    .i_exp9   (r_s2_exp9),
    .o_result (w_rp_result),
    .o_ovf    (w_rp_ovf),
    .o_unf    (w_rp_unf)
  );

  // S3 register: packed result; flags only ever accompany a valid result
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {RW{1'b0}};
      r_out_ovf    <= 1'b0;
      r_out_unf    <= 1'b0;
    end else begin
      r_out_valid  <= r_s2_valid;
      r_out_result <= w_rp_result;
      r_out_ovf    <= r_s2_valid & w_rp_ovf;
      r_out_unf    <= r_s2_valid & w_rp_unf;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_ovf    = r_out_ovf;
  assign bus.out_unf    = r_out_unf;

endmodule

// File: tb/tb_fm_step3.sv
// -----------------------------------------------------------------------------
// tb_fm_step3
// Self-checking bench for fm_step3. Inputs change on the falling edge and
// outputs are sampled on the falling edge; a 3-deep expectation queue models
// the pipeline latency. Expected values come from an arithmetic model of the
// packed-product rules, or from literal values for the directed cases.
// -----------------------------------------------------------------------------
module tb_fm_step3;
  import fp_mac_pkg::*;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;

  fm_step3_if bus_if ();

  fm_step3 dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          valid;
    bit          chk_res;
    int unsigned result;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Count a comparison and report it if it differs
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: exact arithmetic on the product value, RNE on the remainder
  function automatic exp_t model(input bit v, input int unsigned s, input int unsigned p,
                                 input int unsigned ex, input bit sign);
    exp_t        r;
    longint      prod, rem, half;
    int unsigned sh, e, frac;
    r.valid   = v;
    r.chk_res = v;
    r.ovf     = 1'b0;
    r.unf     = 1'b0;
    r.result  = sign ? 32'h40000 : 32'h0;
    prod = (longint'(s) + longint'(p)) % (64'sd1 <<< 22);
    if (prod != 0) begin
      sh   = (prod >= (64'sd1 <<< 21)) ? 11 : 10;
      e    = ex + ((sh == 11) ? 1 : 0);
      frac = int'((prod >>> sh) % 1024);
      rem  = prod % (64'sd1 <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && (frac % 2) == 1)) frac++;
      if (frac == 1024) begin
        frac = 0;
        e++;
      end
      if (e >= 255) begin
        r.result = r.result + 255 * 1024;
        r.ovf    = 1'b1;
      end else if (e == 0) begin
        r.unf = 1'b1;
      end else begin
        r.result = r.result + e * 1024 + frac;
      end
    end
    if (!v) begin
      r.ovf = 1'b0;
      r.unf = 1'b0;
    end
    return r;
  endfunction

  // One cycle: check the output due now, then drive the next operand
  task automatic step_core(input bit v, input int unsigned s, input int unsigned p,
                           input int unsigned ex, input bit sign, input exp_t e_new);
    exp_t e;
    @(negedge CLK);
    e = exp_q.pop_front();
    check_val("out_valid", {31'd0, bus_if.out_valid}, {31'd0, e.valid});
    check_val("out_ovf",   {31'd0, bus_if.out_ovf},   {31'd0, e.ovf});
    check_val("out_unf",   {31'd0, bus_if.out_unf},   {31'd0, e.unf});
    if (e.chk_res) check_val("out_result", {13'd0, bus_if.out_result}, e.result);
    bus_if.in_valid  = v;
    bus_if.temp_s_r9 = s[21:0];
    bus_if.temp_p_r9 = p[21:0];
    bus_if.in_ex     = ex[7:0];
    bus_if.in_sign   = sign;
    exp_q.push_back(e_new);
  endtask

  task automatic step_model(input bit v, input int unsigned s, input int unsigned p,
                            input int unsigned ex, input bit sign);
    step_core(v, s, p, ex, sign, model(v, s, p, ex, sign));
  endtask

  task automatic step_exp(input int unsigned s, input int unsigned p, input int unsigned ex,
                          input bit sign, input int unsigned res, input bit ovf, input bit unf);
    exp_t e;
    e.valid = 1'b1; e.chk_res = 1'b1; e.result = res; e.ovf = ovf; e.unf = unf;
    step_core(1'b1, s, p, ex, sign, e);
  endtask

  task automatic step_rand(input bit v);
    int unsigned s, p, ex;
    if ($urandom_range(0, 15) == 0) begin
      s = 0; p = 0;
    end else begin
      s = $urandom & 32'h3FFFFF;
      p = $urandom & 32'h3FFFFF;
    end
    ex = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 254) : $urandom_range(1, 254);
    step_model(v, s, p, ex, 1'($urandom));
  endtask

  // Pipeline holds only bubbles after reset release
  task automatic refill_idle();
    exp_t e;
    e.valid = 1'b0; e.chk_res = 1'b0; e.result = 0; e.ovf = 1'b0; e.unf = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs();
    check_val("rst_valid",  {31'd0, bus_if.out_valid},  32'd0);
    check_val("rst_result", {13'd0, bus_if.out_result}, 32'd0);
    check_val("rst_ovf",    {31'd0, bus_if.out_ovf},    32'd0);
    check_val("rst_unf",    {31'd0, bus_if.out_unf},    32'd0);
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_ex     = 8'd0;
    bus_if.in_sign   = 1'b0;
    bus_if.temp_p_r9 = 22'd0;
    bus_if.temp_s_r9 = 22'd0;
    #12;
    check_reset_outputs();
    @(negedge CLK);
    RESETn = 1'b1;
    refill_idle();

    // directed cases with literal expectations
    step_exp(32'h100000, 32'h000000, 127, 1'b0, 32'h1FC00, 1'b0, 1'b0); // 1.0 x 1.0
    step_exp(32'h200000, 32'h040000, 127, 1'b0, 32'h20080, 1'b0, 1'b0); // 1.5 x 1.5
    step_exp(32'h100200, 32'h000000, 100, 1'b0, 32'h19000, 1'b0, 1'b0); // tie, even kept
    step_exp(32'h100000, 32'h000600, 100, 1'b0, 32'h19002, 1'b0, 1'b0); // tie, odd rounds up
    step_exp(32'h1FFE00, 32'h000000, 100, 1'b0, 32'h19400, 1'b0, 1'b0); // fraction wraps
    step_exp(32'h200000, 32'h000000, 254, 1'b1, 32'h7FC00, 1'b1, 1'b0); // overflow
    step_exp(32'h000000, 32'h000000, 127, 1'b1, 32'h40000, 1'b0, 1'b0); // zero
    step_exp(32'h100000, 32'h000000, 254, 1'b0, 32'h3F800, 1'b0, 1'b0); // largest normal exp
    step_exp(32'h1FFE00, 32'h000000, 254, 1'b0, 32'h3FC00, 1'b1, 1'b0); // round into overflow
    step_exp(32'h100000, 32'h000000, 0,   1'b1, 32'h40000, 1'b0, 1'b1); // underflow
    step_exp(32'h3FFFFF, 32'h000001, 127, 1'b0, 32'h00000, 1'b0, 1'b0); // add wraps to zero
    step_model(1'b0, 32'h100000, 0, 127, 1'b0);                         // bubble

    // streaming: 8 back-to-back then 2 bubbles, several bursts
    repeat (4) begin
      repeat (8) step_rand(1'b1);
      repeat (2) step_rand(1'b0);
    end

    // random valid pattern
    for (int i = 0; i < 300; i++) step_rand($urandom_range(0, 3) != 0);

    // asynchronous reset in the middle of a stream
    repeat (5) step_rand(1'b1);
    #2 RESETn = 1'b0;
    #1 check_reset_outputs();
    bus_if.in_valid = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    refill_idle();
    repeat (3) step_rand(1'b0);
    for (int i = 0; i < 60; i++) step_rand($urandom_range(0, 1) != 0);

    // drain
    repeat (4) step_model(1'b0, 0, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_step3.md
Name: fm_step3

Overview:
- Final stage of the pipelined floating-point multiplier inside the MAC. Sits directly downstream of the array-multiplier rows 2–9 stage.
- Consumes the running row sum, the last partial-product row, the biased result exponent and the result sign.
- Adds the last partial-product row, normalises, rounds to nearest-even, handles exponent saturation and zero, then packs the product.
- The packed word format is sign[18], exponent[17:10] (bias 127), fraction[9:0]. It feeds the MAC accumulate stage.

Parameters:
- MW, 11, mantissa width including hidden bit; product width is 2*MW = 22.
- EW, 8, exponent width.
- FW, 10, stored fraction width (MW-1).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETn  input  1  reset: asynchronous, active-low.
- in_valid  input  1  qualifies the in_* bundle this cycle.
- in_ex  input  8  biased result exponent (ea+eb-127), already checked as 1..254 by the upstream stage.
- in_sign  input  1  result sign.
- temp_p_r9  input  22  last partial-product row, already aligned.
- temp_s_r9  input  22  accumulated sum of all previous rows.
- out_valid  output  1  qualifies out_* this cycle.
- out_result  output  19  packed product.
- out_ovf  output  1  result saturated to infinity.
- out_unf  output  1  result flushed to zero from a nonzero product.

Behaviour:
- Free-running 3-stage pipeline with no stall. A valid bit travels with the data. Latency is exactly 3 cycles, throughput is 1 per cycle, and bubbles are preserved.
- Reset values: all pipeline registers and all outputs are 0 (out_valid=0, out_result=0, out_ovf=0, out_unf=0). Reset acts asynchronously mid-stream; in-flight data is discarded.
- S1 register:
  - prod = temp_s_r9 + temp_p_r9, modulo 2^22; carry-out is discarded.
  - ex and sign registered, valid registered.
- S2 register (normalise):
  - If prod[21]=1: frac = prod[20:11], guard = prod[10], sticky = OR prod[9:0], exp9 = {0,ex}+1.
  - Otherwise: frac = prod[19:10], guard = prod[9], sticky = OR prod[8:0], exp9 = {0,ex}.
  - zero = (prod==0). Upstream zeroes the partial products of a zero operand.
- S3 register (round/pack):
  - Round up when guard & (sticky | frac[0]).
  - A rounded frac of 0x3FF+1 wraps frac to 0 and sets exp9 = exp9+1.
  - Priority: zero > overflow > underflow > normal.
  - zero: result {sign,8'h00,10'h000}; ovf=0, unf=0.
  - overflow (exp9 ≥ 255): result {sign,8'hFF,10'h000}, out_ovf=1.
  - underflow (exp9 == 0 with nonzero prod): result {sign,0,0}, out_unf=1. This is unreachable given the upstream contract but must be implemented.
  - normal: {sign, exp9[7:0], frac}.
- When valid=0 at a stage, the data registers of that stage still load (don't-care). out_ovf/out_unf are forced to 0 whenever out_valid=0.
- Arithmetic is unsigned. The exponent path is 9 bits internally.

Decomposition:
- Shared package fp_mac_pkg: MW/EW/FW, BIAS=127, EXP_INF=8'hFF, packed-format field offsets (SIGN_BIT=18, EXP_LSB=10).
- One natural sub-module: fm_round_pack (combinational S3 logic: rounding, saturation, packing). It is reusable by the MAC adder's final stage.
- The 22-bit add is inferred; no full_adder array is used here.

Test Plan:
- 1.0×1.0: s=22'h100000, p=0, ex=127, sign=0, valid=1 → 3 cycles later out_valid=1, out_result=19'h1FC00, ovf=unf=0.
- 1.5×1.5 split across rows: s=22'h200000, p=22'h040000, ex=127 → out_result=19'h20080 (exp 128, frac 0x080).
- Round-to-nearest-even:
  - prod 22'h100200 (ex=100) → frac 0x000 (tie, even kept).
  - prod 22'h100600 → frac 0x002.
  - prod 22'h1FFE00 → frac wraps to 0, exp 101.
- Overflow and zero:
  - ex=254, prod=22'h200000, sign=1 → out_result=19'h7FC00, out_ovf=1.
  - prod=0, sign=1 → 19'h40000, ovf=unf=0.
- Streaming with bubbles: 8 back-to-back valids then in_valid=0 for 2 cycles → outputs in order, out_valid pattern delayed by exactly 3.
- RESETn pulsed low mid-stream → outputs clear immediately, out_valid stays 0 until 3 cycles after the next in_valid.
